// File: rtl/spi_pkg.sv
// Shared state encoding and default sizing for the SPI master slice.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      TRANSACT = 2'd2,
      UNLOAD   = 2'd3
   } state_t;

   localparam int DEF_REG_WIDTH     = 8;
   localparam int DEF_COUNTER_WIDTH = $clog2(DEF_REG_WIDTH);
   localparam int DEF_HALF_DIV      = 2;

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response and serial pins of the SPI master.
interface spi_master_if
   import spi_pkg::*;
#(
   parameter int REG_WIDTH     = DEF_REG_WIDTH,
   parameter int COUNTER_WIDTH = $clog2(REG_WIDTH)
);
   logic                     t_start;
   logic [REG_WIDTH-1:0]     d_in_m;
   logic [COUNTER_WIDTH:0]   t_size;
   logic [REG_WIDTH-1:0]     d_out_m;
   logic                     busy;
   logic                     done;
   logic                     cs_n;
   logic                     sclk;
   logic                     mosi;
   logic                     miso;

   modport master (
      input  t_start, d_in_m, t_size, miso,
      output d_out_m, busy, done, cs_n, sclk, mosi
   );

   modport slave (
      output t_start, d_in_m, t_size, miso,
      input  d_out_m, busy, done, cs_n, sclk, mosi
   );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer: rise/fall strobes mark the master_clk cycle whose edge moves sclk.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int HALF_DIV = DEF_HALF_DIV
) (
   input  logic master_clk,
   input  logic rstn,
   input  logic en,
   output logic rise,
   output logic fall
);
   localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [HW-1:0] LAST = HW'(HALF_DIV - 1);

   logic [HW-1:0] half_cnt;
   logic          phase;
   logic          wrap;

   // phase mirrors sclk: low half first, so each bit starts with a full low period
   assign wrap = en && (half_cnt == LAST);
   assign rise = wrap && !phase;
   assign fall = wrap && phase;

   always_ff @(posedge master_clk or negedge rstn) begin
      if (!rstn) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else if (!en) begin
         half_cnt <= '0;
         phase    <= 1'b0;
      end else if (half_cnt == LAST) begin
         half_cnt <= '0;
         phase    <= ~phase;
      end else begin
         half_cnt <= half_cnt + HW'(1);
      end
   end
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: IDLE -> LOAD -> TRANSACT -> UNLOAD, MSB first, up to REG_WIDTH bits.
module spi_master
   import spi_pkg::*;
#(
   parameter int REG_WIDTH     = DEF_REG_WIDTH,
   parameter int COUNTER_WIDTH = $clog2(REG_WIDTH),
   parameter int HALF_DIV      = DEF_HALF_DIV
) (
   input  logic          master_clk,
   input  logic          rstn,
   spi_master_if.master  bus
);
   localparam int SW = COUNTER_WIDTH + 1;
   localparam logic [SW-1:0] MAX_BITS = SW'(REG_WIDTH);

   state_t               state;
   logic [REG_WIDTH-1:0] tx;
   logic [REG_WIDTH-1:0] rx;
   logic [SW-1:0]        bit_cnt;
   logic [SW-1:0]        load_bits;
   logic                 rise;
   logic                 fall;

   assign load_bits = (bus.t_size > MAX_BITS) ? MAX_BITS : bus.t_size;

   spi_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
      .master_clk (master_clk),
      .rstn       (rstn),
      .en         (state == TRANSACT),
      .rise       (rise),
      .fall       (fall)
   );

   always_ff @(posedge master_clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         tx          <= '0;
         rx          <= '0;
         bit_cnt     <= '0;
         bus.d_out_m <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.cs_n    <= 1'b1;
         bus.sclk    <= 1'b0;
         bus.mosi    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.t_start) begin
                  state    <= LOAD;
                  bus.busy <= 1'b1;
               end
            end
            LOAD: begin
               tx      <= bus.d_in_m;
               rx      <= '0;
               bit_cnt <= load_bits;
               // a zero-length request returns to IDLE without touching the bus
               if (load_bits != '0) begin
                  state    <= TRANSACT;
                  bus.cs_n <= 1'b0;
                  bus.mosi <= bus.d_in_m[REG_WIDTH-1];
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            TRANSACT: begin
               if (rise) begin
                  bus.sclk <= 1'b1;
                  rx       <= {rx[REG_WIDTH-2:0], bus.miso};
               end
               if (fall) begin
                  bus.sclk <= 1'b0;
                  tx       <= tx << 1;
                  bus.mosi <= tx[REG_WIDTH-2];
                  bit_cnt  <= bit_cnt - SW'(1);
                  // rx already holds the final bit here, so result and done appear together
                  if (bit_cnt == SW'(1)) begin
                     state       <= UNLOAD;
                     bus.cs_n    <= 1'b1;
                     bus.done    <= 1'b1;
                     bus.d_out_m <= rx;
                  end
               end
            end
            UNLOAD: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               bus.mosi <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, shift-register and data width in bits.
REQ-002 SHALL have parameter COUNTER_WIDTH, default $clog2(REG_WIDTH), so t_size is COUNTER_WIDTH+1 bits.
REQ-003 SHALL have parameter HALF_DIV, default 2, master_clk cycles per sclk half-period (legal values >= 1).
REQ-004 SHALL have port master_clk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port t_start  input  1  transaction request, sampled only in IDLE.
REQ-007 SHALL have port d_in_m  input  REG_WIDTH  transmit word, captured in LOAD.
REQ-008 SHALL have port t_size  input  COUNTER_WIDTH+1  bits to transfer, captured in LOAD.
REQ-009 SHALL have port d_out_m  output  REG_WIDTH  received word, right-aligned, updated in UNLOAD.
REQ-010 SHALL have port busy  output  1  high in LOAD, TRANSACT and UNLOAD.
REQ-011 SHALL have port done  output  1  one-cycle pulse in UNLOAD.
REQ-012 SHALL have port cs_n  output  1  active-low chip select.
REQ-013 SHALL have port sclk  output  1  SPI clock, registered, idle low (mode 0).
REQ-014 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-015 SHALL have port miso  input  1  serial data in, MSB first.

Function
REQ-016 SHALL implement states IDLE, LOAD, TRANSACT, UNLOAD; IDLE->LOAD when t_start=1; LOAD->TRANSACT when captured size != 0, else LOAD->IDLE with no done; TRANSACT->UNLOAD after last bit; UNLOAD->IDLE unconditionally.
REQ-017 SHALL in LOAD capture d_in_m into tx shift register, clear rx shift register, load bit counter with t_size clamped to REG_WIDTH, drive cs_n low and mosi = d_in_m[REG_WIDTH-1].
REQ-018 SHALL keep cs_n low in TRANSACT and drive it high on entering UNLOAD.
REQ-019 SHALL in TRANSACT produce per bit HALF_DIV cycles sclk low then HALF_DIV cycles sclk high.
REQ-020 SHALL on each sclk rising edge shift miso into rx LSB: rx <= {rx[REG_WIDTH-2:0], miso}.
REQ-021 SHALL on each sclk falling edge shift tx left with zero fill, update mosi to new tx MSB and decrement counter.
REQ-022 SHALL leave TRANSACT on the falling edge that brings counter to 0; sclk low thereafter.
REQ-023 SHALL in UNLOAD assign d_out_m <= rx and assert done for exactly one cycle.
REQ-024 SHALL take 2 + 2*HALF_DIV*N cycles from LOAD entry to IDLE return for N = clamped size >= 1.
REQ-025 SHALL ignore t_start and d_in_m/t_size changes outside IDLE; d_out_m holds between transactions.
REQ-026 SHALL for N < REG_WIDTH leave received bits in d_out_m[N-1:0] and upper bits zero.

Reset
REQ-027 SHALL on rstn=0 asynchronously force state IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, d_out_m=0, counters and shift registers 0.
REQ-028 SHALL on reset mid-transaction abort immediately with no done pulse and d_out_m=0.
REQ-029 SHALL release reset synchronously to master_clk and require t_start to start any transfer.

Structure
REQ-030 SHALL place state encodings (IDLE=0, LOAD=1, TRANSACT=2, UNLOAD=3) and default width constants in shared package spi_pkg.
REQ-031 SHALL use one sub-module spi_clk_gen (half-period counter, emits rise/fall strobes, enabled only in TRANSACT).

Verification
REQ-032 SHALL cover: HALF_DIV=2, t_size=8, d_in_m=8'hA5, slave returns 8'h3C -> mosi bits 1,0,1,0,0,1,0,1; d_out_m=8'h3C; done 1 cycle; 34 cycles LOAD to IDLE.
REQ-033 SHALL cover: t_size=0 with t_start -> cs_n stays high, no sclk edges, no done, d_out_m unchanged.
REQ-034 SHALL cover: t_size=4, miso drives 1,0,1,1 -> d_out_m=8'h0B, exactly 4 sclk rising edges.
REQ-035 SHALL cover: t_size=12 (REG_WIDTH=8) -> clamped to 8 sclk pulses.
REQ-036 SHALL cover: rstn low after 3rd sclk rise -> cs_n=1, sclk=0, d_out_m=0 same cycle, no done.
REQ-037 SHALL cover: t_start held high through a transfer -> next transfer starts on the cycle after IDLE return, cs_n high at least one cycle between.
